// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
// Exports the architectural register index type and the fixed register
// numbers that have special meaning: the hard-wired zero register, the
// stack pointer loaded at reset, and the first argument register.
package regfile_pkg;

   localparam int unsigned REG_IDX_W = 5;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_SP   = 2;
   localparam int unsigned REG_A0   = 10;
   localparam int unsigned NUM_ARGS = 8;

endpackage

// File: rtl/multiport_regfile_if.sv
// Bus bundle between a pipeline and the multiport register file.
//   rd_idx / rd_data / rd_busy : read ports, one IDX_W / DATA_WIDTH / 1-bit
//                                slice per port, port 0 in the low slice
//   wr_en / wr_idx / wr_data   : writeback ports, one slice per port
//   iss_en / iss_idx           : issue of an instruction that will write iss_idx
// Protocol: there is no valid/ready pair on this bus. Every strobe
// (wr_en bit, iss_en) is a one-cycle command sampled at the rising clk
// edge and is always accepted; read outputs are combinational and valid in
// the same cycle as rd_idx. The master modport is the pipeline side, the
// slave modport is the register file.
interface multiport_regfile_if
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int IDX_W      = REG_IDX_W
);
   logic [NUM_RD*IDX_W-1:0]      rd_idx;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]            rd_busy;
   logic [NUM_WR-1:0]            wr_en;
   logic [NUM_WR*IDX_W-1:0]      wr_idx;
   logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
   logic                         iss_en;
   logic [IDX_W-1:0]             iss_idx;

   modport master (
      output rd_idx, wr_en, wr_idx, wr_data, iss_en, iss_idx,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_idx, wr_en, wr_idx, wr_data, iss_en, iss_idx,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// One busy bit per architectural register, marking registers whose
// producing instruction has issued but not yet written back.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   iss_en, iss_idx : issue strobe; sets busy[iss_idx] at the next edge
//   wr_en, wr_idx   : writeback strobes; clear busy[wr_idx] at the next edge
//   busy            : registered busy vector, bit 0 is always 0
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int NUM_WR   = 2,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    iss_en,
   input  logic [IDX_W-1:0]        iss_idx,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*IDX_W-1:0] wr_idx,
   output logic [NUM_REGS-1:0]     busy
);

   logic [NUM_REGS-1:0] busy_next;

   // Clears are applied before the set so that a new producer issuing in
   // the same cycle as the old one retires keeps the register busy.
   always_comb begin
      busy_next = busy;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en[w]) begin
            busy_next[wr_idx[w*IDX_W +: IDX_W]] = 1'b0;
         end
      end
      if (iss_en) begin
         busy_next[iss_idx] = 1'b1;
      end
      busy_next[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

endmodule

// File: rtl/multiport_regfile.sv
// Flip-flop based architectural register file with NUM_RD combinational
// read ports (write-through bypass), NUM_WR write ports and an issue
// scoreboard reporting read-after-write hazards per read port.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   sp_init    : value loaded into x2 while reset is high
//   bus        : read / writeback / issue bundle (slave side)
//   args       : registered x10..x17, x10 in the least significant slice
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      sp_init,
   multiport_regfile_if.slave         bus,
   output logic [8*DATA_WIDTH-1:0]    args
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .IDX_W    (IDX_W)
   ) u_scoreboard (
      .clk     (clk),
      .reset   (reset),
      .iss_en  (bus.iss_en),
      .iss_idx (bus.iss_idx),
      .wr_en   (bus.wr_en),
      .wr_idx  (bus.wr_idx),
      .busy    (busy)
   );

   // Storage: x0 is a constant, every other register is its own flop.
   // Ports are scanned in ascending order so the highest port wins a tie.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      if (g == REG_ZERO) begin : g_zero
         assign regs[g] = '0;
      end else begin : g_ff
         logic [DATA_WIDTH-1:0] q;
         always_ff @(posedge clk) begin
            if (reset) begin
               q <= (g == REG_SP) ? sp_init : '0;
            end else begin
               for (int w = 0; w < NUM_WR; w++) begin
                  if (bus.wr_en[w] && (bus.wr_idx[w*IDX_W +: IDX_W] == IDX_W'(g))) begin
                     q <= bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         end
         assign regs[g] = q;
      end
   end

   // Read ports with bypass from same-cycle writebacks.
   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [IDX_W-1:0]      idx;
      logic [DATA_WIDTH-1:0] data;
      logic                  wr_hit;
      logic                  iss_hit;

      assign idx = bus.rd_idx[r*IDX_W +: IDX_W];

      always_comb begin
         data   = regs[idx];
         wr_hit = 1'b0;
         for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w] && (bus.wr_idx[w*IDX_W +: IDX_W] == idx)) begin
               data   = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
               wr_hit = 1'b1;
            end
         end
         if (idx == '0) begin
            data = '0;
         end
      end

      assign iss_hit = bus.iss_en && (bus.iss_idx == idx);

      assign bus.rd_data[r*DATA_WIDTH +: DATA_WIDTH] = data;
      // A retiring write hides the hazard unless a new producer issues now.
      assign bus.rd_busy[r] = busy[idx] & ~(wr_hit & ~iss_hit);
   end

   // Argument registers straight from storage; small files lack some of them.
   for (genvar k = 0; k < NUM_ARGS; k++) begin : g_args
      if (REG_A0 + k < NUM_REGS) begin : g_present
         assign args[k*DATA_WIDTH +: DATA_WIDTH] = regs[REG_A0 + k];
      end else begin : g_absent
         assign args[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
   end

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: directed vectors, a behavioural register
// model checked every cycle, and literal expectations at key points.
module tb_multiport_regfile;

   localparam int DW  = 64;
   localparam int NR  = 32;
   localparam int NRD = 2;
   localparam int NW  = 2;
   localparam int IW  = 5;

   // ---------------- clock / reset ----------------
   logic           clk = 1'b0;
   logic           reset;
   logic [DW-1:0]  sp_init;
   logic [8*DW-1:0] args;

   always #5 clk = ~clk;

   multiport_regfile_if #(.DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NW), .IDX_W(IW)) bus ();

   multiport_regfile #(
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .NUM_RD     (NRD),
      .NUM_WR     (NW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sp_init (sp_init),
      .bus     (bus),
      .args    (args)
   );

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_regs [NR];
   logic          m_busy [NR];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NR; i++) begin
            m_regs[i] <= (i == 2) ? sp_init : '0;
            m_busy[i] <= 1'b0;
         end
      end else begin
         for (int w = 0; w < NW; w++) begin
            if (bus.wr_en[w]) begin
               if (bus.wr_idx[w*IW +: IW] != 0) m_regs[bus.wr_idx[w*IW +: IW]] <= bus.wr_data[w*DW +: DW];
               m_busy[bus.wr_idx[w*IW +: IW]] <= 1'b0;
            end
         end
         if (bus.iss_en && bus.iss_idx != 0) m_busy[bus.iss_idx] <= 1'b1;
      end
   end

   function automatic logic [DW-1:0] exp_data(input logic [IW-1:0] idx);
      logic [DW-1:0] v;
      v = m_regs[idx];
      for (int w = 0; w < NW; w++)
         if (bus.wr_en[w] && bus.wr_idx[w*IW +: IW] == idx) v = bus.wr_data[w*DW +: DW];
      if (idx == 0) v = '0;
      return v;
   endfunction

   function automatic logic exp_busy(input logic [IW-1:0] idx);
      logic wr_hit;
      logic iss_hit;
      wr_hit = 1'b0;
      for (int w = 0; w < NW; w++)
         if (bus.wr_en[w] && bus.wr_idx[w*IW +: IW] == idx) wr_hit = 1'b1;
      iss_hit = bus.iss_en && (bus.iss_idx == idx);
      return (idx != 0) && m_busy[idx] && !(wr_hit && !iss_hit);
   endfunction

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clk) begin
      #2;
      if (check_en) begin
         for (int r = 0; r < NRD; r++) begin
            chk($sformatf("model rd_data[%0d] x%0d", r, bus.rd_idx[r*IW +: IW]),
                bus.rd_data[r*DW +: DW], exp_data(bus.rd_idx[r*IW +: IW]));
            chk($sformatf("model rd_busy[%0d] x%0d", r, bus.rd_idx[r*IW +: IW]),
                DW'(bus.rd_busy[r]), DW'(exp_busy(bus.rd_idx[r*IW +: IW])));
         end
         for (int k = 0; k < 8; k++)
            chk($sformatf("model args[%0d]", k), args[k*DW +: DW], m_regs[10+k]);
      end
   end

   // ---------------- driver ----------------
   task automatic cyc(input logic rst, input logic [NW-1:0] we,
                      input logic [IW-1:0] wi0, input logic [DW-1:0] wd0,
                      input logic [IW-1:0] wi1, input logic [DW-1:0] wd1,
                      input logic ie, input logic [IW-1:0] ii,
                      input logic [IW-1:0] r0, input logic [IW-1:0] r1);
      @(negedge clk);
      reset       = rst;
      bus.wr_en   = we;
      bus.wr_idx  = {wi1, wi0};
      bus.wr_data = {wd1, wd0};
      bus.iss_en  = ie;
      bus.iss_idx = ii;
      bus.rd_idx  = {r1, r0};
      #4;
   endtask

   function automatic logic [DW-1:0] rd0();
      return bus.rd_data[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] rd1();
      return bus.rd_data[2*DW-1:DW];
   endfunction

   // ---------------- directed stimulus ----------------
   initial begin
      reset       = 1'b1;
      sp_init     = 64'h8000_0000;
      bus.wr_en   = '0;
      bus.wr_idx  = '0;
      bus.wr_data = '0;
      bus.iss_en  = 1'b0;
      bus.iss_idx = '0;
      bus.rd_idx  = '0;
      repeat (2) @(negedge clk);
      reset    = 1'b0;
      check_en = 1'b1;

      // reset state
      for (int i = 0; i < NR; i++) begin
         cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, IW'(i), IW'(NR-1-i));
         chk($sformatf("reset x%0d", i), rd0(), (i == 2) ? 64'h8000_0000 : 64'h0);
         chk($sformatf("reset busy x%0d", i), DW'(bus.rd_busy[0]), 64'h0);
      end

      // bypass then storage of x5
      cyc(0, 2'b01, 5, 64'hDEAD, 0, 0, 0, 0, 5, 0);
      chk("bypass x5", rd0(), 64'hDEAD);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);
      chk("stored x5", rd0(), 64'hDEAD);

      // both ports write x7, port 1 wins
      cyc(0, 2'b11, 7, 64'h11, 7, 64'h22, 0, 0, 7, 0);
      chk("dual write bypass x7", rd0(), 64'h22);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 0);
      chk("dual write stored x7", rd0(), 64'h22);

      // issue x9, busy 0,1,1, writeback 0, then 0
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9);
      chk("busy x9 issue cycle", DW'(bus.rd_busy[1]), 64'h0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
      chk("busy x9 +1", DW'(bus.rd_busy[1]), 64'h1);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
      chk("busy x9 +2", DW'(bus.rd_busy[1]), 64'h1);
      cyc(0, 2'b10, 0, 0, 9, 64'h99, 0, 0, 0, 9);
      chk("busy x9 writeback", DW'(bus.rd_busy[1]), 64'h0);
      chk("data x9 writeback", rd1(), 64'h99);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
      chk("busy x9 after", DW'(bus.rd_busy[1]), 64'h0);
      chk("data x9 after", rd1(), 64'h99);

      // issue and write same register while busy: set wins
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9);
      cyc(0, 2'b01, 9, 64'h77, 0, 0, 1, 9, 0, 9);
      chk("busy x9 issue+write", DW'(bus.rd_busy[1]), 64'h1);
      chk("data x9 issue+write", rd1(), 64'h77);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
      chk("busy x9 set wins", DW'(bus.rd_busy[1]), 64'h1);
      chk("data x9 updated", rd1(), 64'h77);
      cyc(0, 2'b01, 9, 64'h78, 0, 0, 0, 0, 0, 9);
      chk("busy x9 retire", DW'(bus.rd_busy[1]), 64'h0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9);
      chk("busy x9 clear", DW'(bus.rd_busy[1]), 64'h0);

      // x0 is immutable and never busy; args are registered
      cyc(0, 2'b01, 0, 64'hFF, 0, 0, 1, 0, 0, 0);
      chk("x0 write bypass", rd0(), 64'h0);
      chk("x0 busy", DW'(bus.rd_busy[0]), 64'h0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("x0 after write", rd0(), 64'h0);
      chk("x0 busy after issue", DW'(bus.rd_busy[0]), 64'h0);
      cyc(0, 2'b10, 0, 0, 12, 64'h3, 0, 0, 0, 12);
      chk("args a2 same cycle", args[2*DW +: DW], 64'h0);
      chk("x12 bypass", rd1(), 64'h3);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 12);
      chk("args a2 next cycle", args[2*DW +: DW], 64'h3);

      // reset mid-operation discards writes and issues
      cyc(0, 2'b00, 0, 0, 0, 0, 1, 20, 20, 0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 20, 0);
      chk("busy x20 before reset", DW'(bus.rd_busy[0]), 64'h1);
      cyc(1, 2'b11, 20, 64'h55, 21, 64'h66, 1, 21, 20, 21);
      cyc(0, 2'b01, 20, 64'h66, 0, 0, 1, 21, 5, 2);
      chk("x5 cleared by reset", rd0(), 64'h0);
      chk("x2 reloaded", rd1(), 64'h8000_0000);
      chk("busy x2 after reset", DW'(bus.rd_busy[1]), 64'h0);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 20, 21);
      chk("x20 first post-reset write", rd0(), 64'h66);
      chk("busy x21 first post-reset issue", DW'(bus.rd_busy[1]), 64'h1);
      cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 12, 21);
      chk("x12 cleared by reset", rd0(), 64'h0);

      // fill every register through alternating ports, then read back
      for (int i = 1; i < NR; i++)
         cyc(0, (i % 2) ? 2'b10 : 2'b01, IW'(i), DW'(i) * 64'h0101_0101,
             IW'(i), DW'(i) * 64'h0101_0101, 0, 0, IW'(i-1), IW'(i));
      for (int i = 0; i < NR; i++) begin
         cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, IW'(i), IW'(NR-1-i));
         chk($sformatf("fill x%0d", i), rd0(), DW'(i) * 64'h0101_0101);
      end

      check_en = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
